adc_fifo_to_frame: RTL and testbench
====================================

ADC_FIFO_TO_FRAME -- requirements
Module: adc_fifo_to_frame

Interface
REQ-001 SHALL have parameter WORDS, default 9: number of 32-bit words popped per frame (legal range 1..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: idle cycles allowed mid-frame before the partial frame is discarded (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port pop_valid, input, 1: FIFO has a word.
REQ-006 SHALL have port pop_data, input, 32: FIFO head word.
REQ-007 SHALL have port pop_ready, output, 1: block accepts the word this cycle.
REQ-008 SHALL have port frame_valid, output, 1: assembled frame available; held until accepted.
REQ-009 SHALL have port frame_words_packed, output, 32*WORDS: word k at bits [32k+31:32k].
REQ-010 SHALL have port frame_ready, input, 1: consumer accepts the frame.
REQ-011 SHALL have port flush, input, 1: discard any partial or held frame.
REQ-012 SHALL have port busy, output, 1: partial frame in progress or frame held.
REQ-013 SHALL have port frame_count, output, 16: frames accepted by consumer, wraps modulo 2^16.
REQ-014 SHALL have port partial_dropped, output, 1: 1-cycle pulse when words are discarded.

Function
REQ-015 SHALL implement two states: FILL (collecting words) and HOLD (presenting a complete frame).
REQ-016 SHALL drive pop_ready = (state==FILL) && !flush, combinationally.
REQ-017 SHALL accept a word on a cycle where pop_valid && pop_ready are both high, write it to slot idx, and increment idx.
REQ-018 SHALL go to HOLD on acceptance of word WORDS-1, so that frame_valid is high the following cycle (1-cycle latency).
REQ-019 SHALL keep frame_valid high and frame_words_packed stable in HOLD until frame_ready is high, with no pops while in HOLD.
REQ-020 SHALL, on frame_valid && frame_ready, return to FILL with idx=0 and increment frame_count in the same edge.
REQ-021 SHALL, on flush in FILL with idx!=0, clear idx and pulse partial_dropped the next cycle; with idx==0 there is no pulse.
REQ-022 SHALL, on flush in HOLD, drop the held frame, return to FILL with idx=0, pulse partial_dropped, and leave frame_count unchanged; flush has priority over a simultaneous frame_ready.
REQ-023 SHALL drive busy = (idx!=0) || (state==HOLD).
REQ-024 SHALL NOT clear unwritten slots or the packed output on frame completion; only frame_valid qualifies the data.

Reset
REQ-025 SHALL, on rst (which overrides flush and all handshakes), set state=FILL, idx=0, frame_valid=0, frame_words_packed=0, frame_count=0, partial_dropped=0, and timeout counter=0.
REQ-026 SHALL, on rst mid-frame or in HOLD, discard data without pulsing partial_dropped.

Configuration
REQ-027 SHALL compile the mid-frame timeout in when ADC_FIFO_TO_FRAME_TIMEOUT_EN is defined: in FILL with idx!=0, a counter increments on each cycle with no accepted word, clears on every accepted word, and on reaching TIMEOUT_CYC clears idx and pulses partial_dropped.
REQ-028 SHALL, without ADC_FIFO_TO_FRAME_TIMEOUT_EN, have no timeout counter (a partial frame waits indefinitely); TIMEOUT_CYC is then ignored and all ports are unchanged.

Structure
REQ-029 SHALL take the word width (32) and the default frame length (9) from the shared package adc_stream_pkg, which the frame-to-FIFO push side also uses.
REQ-030 SHALL place the timeout counter in sub-module adc_frame_timeout (inputs: enable, kick; output: expire pulse), instantiated only when the macro is defined.

Verification
REQ-031 SHALL cover: WORDS=9, pop_valid held high, frame_ready high -> 9 pops, frame_valid high 1 cycle after the 9th pop, frame_count=1.
REQ-032 SHALL cover: frame_ready low for 20 cycles after completion -> pop_ready low, data stable for all 20 cycles, frame_count unchanged until accept.
REQ-033 SHALL cover: flush after 4 words -> partial_dropped pulses once, next 9 pops form a clean frame with word0 = the 5th FIFO word.
REQ-034 SHALL cover: flush and frame_ready in the same HOLD cycle -> frame dropped, frame_count unchanged, partial_dropped=1.
REQ-035 SHALL cover: with the macro defined and TIMEOUT_CYC=16, 3 words then 16 idle cycles -> partial_dropped pulse, idx=0, busy low.
REQ-036 SHALL cover: 65536 accepted frames -> frame_count wraps to 0.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// rtl/adc_stream_pkg.sv - shared ADC stream word/frame constants and frame FSM state type
package adc_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int FRAME_WORDS_DEF = 9;
    localparam int FRAME_CNT_W     = 16;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } frame_state_e;

    // Slot index width; a one-word frame still needs a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adc_fifo_to_frame_if.sv
// rtl/adc_fifo_to_frame_if.sv - FIFO pop and frame handshake bundle for adc_fifo_to_frame
interface adc_fifo_to_frame_if #(
    parameter int WORDS = adc_stream_pkg::FRAME_WORDS_DEF
) ();

    logic                                    pop_valid;
    logic [adc_stream_pkg::WORD_W-1:0]       pop_data;
    logic                                    pop_ready;
    logic                                    frame_valid;
    logic [adc_stream_pkg::WORD_W*WORDS-1:0] frame_words_packed;
    logic                                    frame_ready;

    modport master (
        output pop_valid, pop_data, frame_ready,
        input  pop_ready, frame_valid, frame_words_packed
    );

    modport slave (
        input  pop_valid, pop_data, frame_ready,
        output pop_ready, frame_valid, frame_words_packed
    );

endinterface

// File: rtl/adc_frame_timeout.sv
// rtl/adc_frame_timeout.sv - idle-cycle watchdog that pulses expire after TIMEOUT_CYC quiet cycles
module adc_frame_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    logic [15:0] cnt_q;

    // Fires on the idle cycle that brings the count up to TIMEOUT_CYC.
    assign expire = enable && !kick && (cnt_q == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || !enable || kick || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/adc_fifo_to_frame.sv
// rtl/adc_fifo_to_frame.sv - packs WORDS FIFO words into a frame; mid-frame timeout under ADC_FIFO_TO_FRAME_TIMEOUT_EN
module adc_fifo_to_frame
    import adc_stream_pkg::*;
#(
    parameter int WORDS       = FRAME_WORDS_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_fifo_to_frame_if.slave     bus,
    input  logic                   flush,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   partial_dropped
);

    localparam int              IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    frame_state_e            state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W*WORDS-1:0] frame_q;
    logic [FRAME_CNT_W-1:0]  frame_count_q;
    logic                    drop_q, drop_d;
    logic                    accept, count_en, expire;

    assign bus.pop_ready = (state_q == ST_FILL) && !flush;
    assign accept        = bus.pop_valid && bus.pop_ready;

`ifdef ADC_FIFO_TO_FRAME_TIMEOUT_EN
    adc_frame_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable ((state_q == ST_FILL) && (idx_q != '0) && !flush),
        .kick   (accept),
        .expire (expire)
    );
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign expire             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over both word acceptance and a simultaneous frame_ready.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drop_d   = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (flush) begin
                    idx_d  = '0;
                    drop_d = (idx_q != '0);
                end else if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (expire) begin
                    idx_d  = '0;
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_FILL;
                    drop_d  = 1'b1;
                end else if (bus.frame_ready) begin
                    state_d  = ST_FILL;
                    count_en = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Slots are only overwritten, never cleared; frame_valid qualifies the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            frame_q       <= '0;
            frame_count_q <= '0;
            drop_q        <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            drop_q <= drop_d;
            if (count_en) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
            if (accept) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        frame_q[k*WORD_W +: WORD_W] <= bus.pop_data;
                    end
                end
            end
        end
    end

    assign bus.frame_valid        = (state_q == ST_HOLD);
    assign bus.frame_words_packed = frame_q;
    assign busy                   = (idx_q != '0) || (state_q == ST_HOLD);
    assign frame_count            = frame_count_q;
    assign partial_dropped        = drop_q;

endmodule

// File: tb/tb_adc_fifo_to_frame.sv
// tb/tb_adc_fifo_to_frame.sv - directed self-checking bench for adc_fifo_to_frame
module tb_adc_fifo_to_frame;

    localparam int WORDS = 9;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        busy;
    logic [15:0] frame_count;
    logic        partial_dropped;

    int n_vec = 0;
    int n_err = 0;
    int next_w = 0;

    adc_fifo_to_frame_if #(.WORDS(WORDS)) bus ();

    adc_fifo_to_frame #(
        .WORDS       (WORDS),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .flush           (flush),
        .busy            (busy),
        .frame_count     (frame_count),
        .partial_dropped (partial_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fifo_word(input int n);
        return {8'hA5, 8'(n), 16'(n * 7 + 3)};
    endfunction

    function automatic logic [31:0] slot(input int k);
        return bus.frame_words_packed[k*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Presents n consecutive FIFO words, each accepted on the following rising edge.
    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pop_valid = 1'b1;
            bus.pop_data  = fifo_word(next_w);
            #1;
            chk("pop_ready_fill", 64'(bus.pop_ready), 64'd1);
            @(negedge clk);
            next_w++;
        end
        bus.pop_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b1;
        bus.pop_valid   = 1'b1;
        bus.pop_data    = 32'hDEAD_BEEF;
        bus.frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        flush         = 1'b0;
        bus.pop_valid = 1'b0;
        #1;
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_partial_dropped", 64'(partial_dropped), 64'd0);
        chk("rst_packed_w0", 64'(slot(0)), 64'd0);
        chk("rst_packed_w8", 64'(slot(8)), 64'd0);
        chk("rst_pop_ready", 64'(bus.pop_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame with frame_ready already high.
        push(1);
        chk("a_busy_mid", 64'(busy), 64'd1);
        push(7);
        chk("a_valid_before_last", 64'(bus.frame_valid), 64'd0);
        push(1);
        bus.pop_valid = 1'b1;
        #1;
        chk("a_frame_valid", 64'(bus.frame_valid), 64'd1);
        chk("a_pop_ready_hold", 64'(bus.pop_ready), 64'd0);
        chk("a_w0", 64'(slot(0)), 64'(fifo_word(0)));
        chk("a_w4", 64'(slot(4)), 64'(fifo_word(4)));
        chk("a_w8", 64'(slot(8)), 64'(fifo_word(8)));
        chk("a_count_before", 64'(frame_count), 64'd0);
        @(negedge clk);
        bus.pop_valid = 1'b0;
        chk("a_count_after", 64'(frame_count), 64'd1);
        chk("a_valid_after", 64'(bus.frame_valid), 64'd0);
        chk("a_busy_after", 64'(busy), 64'd0);

        // Back-pressure: frame held for 20 cycles.
        bus.frame_ready = 1'b0;
        push(9);
        bus.pop_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("b_pop_ready", 64'(bus.pop_ready), 64'd0);
            chk("b_valid", 64'(bus.frame_valid), 64'd1);
            chk("b_w0", 64'(slot(0)), 64'(fifo_word(9)));
            chk("b_w8", 64'(slot(8)), 64'(fifo_word(17)));
            chk("b_count", 64'(frame_count), 64'd1);
            @(negedge clk);
        end
        bus.pop_valid   = 1'b0;
        bus.frame_ready = 1'b1;
        @(negedge clk);
        chk("b_count_after", 64'(frame_count), 64'd2);
        chk("b_valid_after", 64'(bus.frame_valid), 64'd0);

        // Flush with idx==0 gives no pulse.
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("c_idle_flush_pd", 64'(partial_dropped), 64'd0);

        // Flush after 4 words, then a clean frame.
        push(4);
        chk("c_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        bus.pop_valid = 1'b1;
        bus.pop_data  = fifo_word(next_w);
        #1;
        chk("c_pop_ready_flush", 64'(bus.pop_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        bus.pop_valid = 1'b0;
        chk("c_pd_pulse", 64'(partial_dropped), 64'd1);
        chk("c_busy_after", 64'(busy), 64'd0);
        @(negedge clk);
        chk("c_pd_once", 64'(partial_dropped), 64'd0);
        bus.frame_ready = 1'b0;
        push(9);
        chk("c_valid", 64'(bus.frame_valid), 64'd1);
        chk("c_w0", 64'(slot(0)), 64'(fifo_word(22)));
        chk("c_w4", 64'(slot(4)), 64'(fifo_word(26)));
        chk("c_w8", 64'(slot(8)), 64'(fifo_word(30)));
        bus.frame_ready = 1'b1;
        @(negedge clk);
        chk("c_count", 64'(frame_count), 64'd3);

        // Flush and frame_ready together in HOLD.
        bus.frame_ready = 1'b0;
        push(9);
        chk("d_valid", 64'(bus.frame_valid), 64'd1);
        flush           = 1'b1;
        bus.frame_ready = 1'b1;
        @(negedge clk);
        flush           = 1'b0;
        bus.frame_ready = 1'b0;
        chk("d_valid_after", 64'(bus.frame_valid), 64'd0);
        chk("d_count", 64'(frame_count), 64'd3);
        chk("d_pd", 64'(partial_dropped), 64'd1);
        chk("d_busy", 64'(busy), 64'd0);
        chk("d_w0_kept", 64'(slot(0)), 64'(fifo_word(31)));
        @(negedge clk);
        chk("d_pd_once", 64'(partial_dropped), 64'd0);

        // Idle partial frame: timeout drop, or indefinite wait without the feature.
        push(3);
        repeat (TOUT - 1) @(negedge clk);
        chk("e_pd_early", 64'(partial_dropped), 64'd0);
        chk("e_busy_early", 64'(busy), 64'd1);
        @(negedge clk);
`ifdef ADC_FIFO_TO_FRAME_TIMEOUT_EN
        chk("e_timeout_pd", 64'(partial_dropped), 64'd1);
        chk("e_timeout_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("e_timeout_pd_once", 64'(partial_dropped), 64'd0);
`else
        chk("e_wait_pd", 64'(partial_dropped), 64'd0);
        chk("e_wait_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("e_wait_flush_pd", 64'(partial_dropped), 64'd1);
`endif

        // Reset mid-frame discards silently.
        push(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("f_pd", 64'(partial_dropped), 64'd0);
        chk("f_busy", 64'(busy), 64'd0);
        chk("f_count", 64'(frame_count), 64'd0);
        chk("f_w0", 64'(slot(0)), 64'd0);
        @(negedge clk);
        chk("f_pd_next", 64'(partial_dropped), 64'd0);

        // Counter wrap: preload to the last value before 2^16, then one accepted frame.
        bus.frame_ready = 1'b1;
        push(9);
        @(negedge clk);
        chk("g_count_1", 64'(frame_count), 64'd1);
        force dut.frame_count_q = 16'hFFFF;
        #1;
        release dut.frame_count_q;
        #1;
        chk("g_count_preload", 64'(frame_count), 64'hFFFF);
        @(negedge clk);
        push(9);
        chk("g_valid", 64'(bus.frame_valid), 64'd1);
        @(negedge clk);
        chk("g_count_wrap", 64'(frame_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
